// File: rtl/noc_local_injector.sv
// noc_local_injector
// Packet source for one router Local input port. Accepts a command (target {X,Y}, payload
// length) and a payload word stream, then serialises header, size and payload flits toward
// the router under its credit-based flow control.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_target = {X,Y}, cmd_len = payload flits
//   pl_valid/pl_ready       payload handshake; pl_data = payload word
//   tx, data_out            flit valid and flit toward router (router rx / data_in)
//   credit_i                router credit; a flit moves on an edge with tx && credit_i
//   busy                    packet in progress
//   pkt_sent                one-cycle pulse after the last flit has moved
//   stall_cycles            (only with INJ_STALL_CNT_EN) saturating count of tx && !credit_i
//                           cycles since the last command accept
//
// Optional feature macro: INJ_STALL_CNT_EN.
// A reset mid-packet aborts it; whatever already reached the network is not recovered.
module noc_local_injector #(
    parameter int unsigned TAM_FLIT   = 16,
    parameter int unsigned METADEFLIT = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TAM_FLIT-1:0] cmd_target,
    input  logic [TAM_FLIT-1:0] cmd_len,
    input  logic                pl_valid,
    output logic                pl_ready,
    input  logic [TAM_FLIT-1:0] pl_data,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    output logic                busy,
`ifdef INJ_STALL_CNT_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic                pkt_sent
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StHeader, StSize, StPayload} state_e;

    state_e                state_q, state_d;
    logic                  tx_q, tx_d;
    logic [TAM_FLIT-1:0]   data_q, data_d;
    logic [TAM_FLIT-1:0]   len_q, len_d;
    logic [TAM_FLIT-1:0]   send_cnt_q, send_cnt_d;
    logic [TAM_FLIT-1:0]   acc_cnt_q, acc_cnt_d;
    logic                  pkt_sent_q, pkt_sent_d;

    logic [TAM_FLIT-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]       fifo_cnt_q;

    logic xfer, fifo_empty, fifo_full, cmd_accept, push, pop;
    logic [TAM_FLIT-1:0] header;

    assign xfer       = tx_q & credit_i;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CntW'(FIFO_DEPTH));
    assign cmd_ready  = ~reset & (state_q == StIdle) & ~pkt_sent_q;
    assign cmd_accept = cmd_valid & cmd_ready;
    // Header flit is {X, Y}, each coordinate METADEFLIT bits wide.
    assign header     = {cmd_target[TAM_FLIT-1 -: METADEFLIT], cmd_target[METADEFLIT-1:0]};

    // pop depends only on registered state and credit_i, so a full FIFO can still take a word
    // in the same cycle that its head is moved into data_out.
    assign pl_ready = ~reset & (state_q != StIdle) & (acc_cnt_q != '0) & (~fifo_full | pop);
    assign push     = pl_valid & pl_ready;

    assign tx       = tx_q;
    assign data_out = data_q;
    assign busy     = ~reset & (state_q != StIdle);
    assign pkt_sent = pkt_sent_q;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        data_d     = data_q;
        len_d      = len_q;
        send_cnt_d = send_cnt_q;
        pkt_sent_d = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    state_d    = StHeader;
                    tx_d       = 1'b1;
                    data_d     = header;
                    len_d      = cmd_len;
                    send_cnt_d = cmd_len;
                end
            end
            StHeader: begin
                if (xfer) begin
                    data_d  = len_q;
                    state_d = StSize;
                end
            end
            StSize: begin
                if (xfer) begin
                    if (len_q == '0) begin
                        tx_d       = 1'b0;
                        pkt_sent_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StPayload;
                        tx_d    = ~fifo_empty;
                        if (!fifo_empty) begin
                            data_d = fifo_mem[rd_ptr_q];
                            pop    = 1'b1;
                        end
                    end
                end
            end
            StPayload: begin
                if (xfer) begin
                    send_cnt_d = send_cnt_q - TAM_FLIT'(1);
                    if (send_cnt_q == TAM_FLIT'(1)) begin
                        tx_d       = 1'b0;
                        pkt_sent_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        tx_d = ~fifo_empty;
                        if (!fifo_empty) begin
                            data_d = fifo_mem[rd_ptr_q];
                            pop    = 1'b1;
                        end
                    end
                end else if (!tx_q && !fifo_empty) begin
                    // Refill an empty output slot; a word pushed this cycle waits one cycle.
                    tx_d   = 1'b1;
                    data_d = fifo_mem[rd_ptr_q];
                    pop    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (cmd_accept) begin
            acc_cnt_d = cmd_len;
        end else if (push) begin
            acc_cnt_d = acc_cnt_q - TAM_FLIT'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            tx_q       <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
            send_cnt_q <= '0;
            acc_cnt_q  <= '0;
            pkt_sent_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            data_q     <= data_d;
            len_q      <= len_d;
            send_cnt_q <= send_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            pkt_sent_q <= pkt_sent_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= pl_data;
    end

`ifdef INJ_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset || cmd_accept) begin
            stall_q <= '0;
        end else if (tx_q && !credit_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
